// File: rtl/sram_bus_arbiter.sv
// Arbitrates the core's fetch and data sram-like ports onto one single-outstanding bus,
// holding completed results until both ports have finished and the pipeline advances.
module sram_bus_arbiter #(
  parameter bit PHYS_MAP   = 1'b1,
  parameter bit INST_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  output logic        instrStall,

  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        dataStall,

  output logic        mem_req,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    D_REQ,
    D_WAIT,
    I_REQ,
    I_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        i_pend, d_pend, advance;
  logic [31:0] sel_addr;

  always_comb begin
    i_pend     = inst_sram_en & ~i_done_q;
    d_pend     = data_sram_en & ~d_done_q;
    instrStall = i_pend;
    dataStall  = d_pend;
    advance    = ~i_pend & ~d_pend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (INST_FIRST) begin
          if (i_pend)      state_d = I_REQ;
          else if (d_pend) state_d = D_REQ;
        end else begin
          if (d_pend)      state_d = D_REQ;
          else if (i_pend) state_d = I_REQ;
        end
      end
      D_REQ:   if (mem_addr_ok) state_d = D_WAIT;
      D_WAIT:  if (mem_data_ok) state_d = IDLE;
      I_REQ:   if (mem_addr_ok) state_d = I_WAIT;
      I_WAIT:  if (mem_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_wstrb = '0;
    mem_wdata = '0;
    sel_addr  = '0;
    case (state_q)
      D_REQ: begin
        mem_req   = 1'b1;
        mem_wstrb = data_sram_wen;
        mem_wdata = data_sram_wdata;
        sel_addr  = data_sram_addr;
      end
      I_REQ: begin
        mem_req   = 1'b1;
        sel_addr  = inst_sram_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (PHYS_MAP && (sel_addr[31:30] == 2'b10)) begin
      mem_addr = {3'b000, sel_addr[28:0]};
    end else begin
      mem_addr = sel_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  // A completion landing on an advance cycle (port dropped its enable) still sets done;
  // the stale flag is cleared by the following advance.
  always_comb begin
    i_done_d     = i_done_q;
    d_done_d     = d_done_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    if (advance) begin
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end
    if ((state_q == I_WAIT) && mem_data_ok) begin
      i_done_d     = 1'b1;
      inst_rdata_d = mem_rdata;
    end
    if ((state_q == D_WAIT) && mem_data_ok) begin
      d_done_d     = 1'b1;
      data_rdata_d = mem_rdata;
    end
  end

  always_comb begin
    inst_sram_rdata = inst_rdata_q;
    data_sram_rdata = data_rdata_q;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios plus a randomized core/bus run
// checked against a transaction-level reference model.
module tb_sram_bus_arbiter;

  logic        clk;
  logic        rst;

  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        instrStall;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        dataStall;
  logic        mem_req;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  logic        a_inst_sram_en;
  logic [31:0] a_inst_sram_addr;
  logic [31:0] a_inst_sram_rdata;
  logic        a_instrStall;
  logic        a_data_sram_en;
  logic [3:0]  a_data_sram_wen;
  logic [31:0] a_data_sram_addr;
  logic [31:0] a_data_sram_wdata;
  logic [31:0] a_data_sram_rdata;
  logic        a_dataStall;
  logic        a_mem_req;
  logic [3:0]  a_mem_wstrb;
  logic [31:0] a_mem_addr;
  logic [31:0] a_mem_wdata;
  logic        a_mem_addr_ok;
  logic        a_mem_data_ok;
  logic [31:0] a_mem_rdata;

  int n_vec = 0;
  int n_err = 0;
  int acc_cnt = 0;

  typedef struct {
    logic        is_inst;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic [31:0] mem_m [logic [31:0]];

  sram_bus_arbiter #(.PHYS_MAP(1'b1), .INST_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata), .instrStall(instrStall),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .dataStall(dataStall),
    .mem_req(mem_req), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  sram_bus_arbiter #(.PHYS_MAP(1'b0), .INST_FIRST(1'b1)) dut_alt (
    .clk(clk), .rst(rst),
    .inst_sram_en(a_inst_sram_en), .inst_sram_addr(a_inst_sram_addr),
    .inst_sram_rdata(a_inst_sram_rdata), .instrStall(a_instrStall),
    .data_sram_en(a_data_sram_en), .data_sram_wen(a_data_sram_wen),
    .data_sram_addr(a_data_sram_addr), .data_sram_wdata(a_data_sram_wdata),
    .data_sram_rdata(a_data_sram_rdata), .dataStall(a_dataStall),
    .mem_req(a_mem_req), .mem_wstrb(a_mem_wstrb), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_addr_ok(a_mem_addr_ok),
    .mem_data_ok(a_mem_data_ok), .mem_rdata(a_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req && mem_addr_ok) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] map_addr(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'hC000_0000) return a & 32'h1FFF_FFFF;
    return a;
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    logic [31:0] key;
    key = {a[31:2], 2'b00};
    if (mem_m.exists(key)) return mem_m[key];
    return key ^ 32'hA5A5_0F0F;
  endfunction

  function automatic void mem_write(input logic [31:0] a, input logic [3:0] be,
                                    input logic [31:0] wd);
    logic [31:0] v;
    v = mem_read(a);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
    end
    mem_m[{a[31:2], 2'b00}] = v;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    case ($urandom_range(0, 3))
      0:       base = 32'h0000_1000;
      1:       base = 32'h8000_1000;
      2:       base = 32'hA000_1000;
      default: base = 32'hBFC0_0000;
    endcase
    return base + 32'($urandom_range(0, 7) * 4);
  endfunction

  task automatic cyc();
    @(negedge clk);
    mem_addr_ok   = 1'b0;
    mem_data_ok   = 1'b0;
    mem_rdata     = '0;
    a_mem_addr_ok = 1'b0;
    a_mem_data_ok = 1'b0;
    a_mem_rdata   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0000;
    data_sram_en = 1'b0; data_sram_wen = '0; data_sram_addr = '0; data_sram_wdata = '0;
    a_inst_sram_en = 1'b0; a_inst_sram_addr = '0;
    a_data_sram_en = 1'b0; a_data_sram_wen = '0; a_data_sram_addr = '0; a_data_sram_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    a_mem_addr_ok = 1'b0; a_mem_data_ok = 1'b0; a_mem_rdata = '0;
    cyc();
    cyc(); rst = 1'b0; #1;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    n_vec++; if (instrStall !== 1'b1) begin n_err++; $display("FAIL reset_instrStall: got %b expected 1", instrStall); end
    n_vec++; if (dataStall !== 1'b0) begin n_err++; $display("FAIL reset_dataStall: got %b expected 0", dataStall); end
    n_vec++; if (inst_sram_rdata !== 32'h0) begin n_err++; $display("FAIL reset_inst_rdata: got %h expected 0", inst_sram_rdata); end
    n_vec++; if (data_sram_rdata !== 32'h0) begin n_err++; $display("FAIL reset_data_rdata: got %h expected 0", data_sram_rdata); end
    inst_sram_en = 1'b0;
    cyc();
  endtask

  task automatic test_fetch_only();
    cyc(); inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0000; #1;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL fetch_idle_req: got %b expected 0", mem_req); end
    cyc(); mem_addr_ok = 1'b1; #1;
    n_vec++; if ({mem_req, mem_wstrb, mem_addr} !== {1'b1, 4'h0, 32'h1FC0_0000})
      begin n_err++; $display("FAIL fetch_req: got req=%b wstrb=%h addr=%h expected 1/0/1fc00000", mem_req, mem_wstrb, mem_addr); end
    cyc(); mem_data_ok = 1'b1; mem_rdata = 32'h2408_0001; #1;
    n_vec++; if ({mem_req, instrStall} !== 2'b01) begin n_err++; $display("FAIL fetch_wait: got req=%b stall=%b expected 0/1", mem_req, instrStall); end
    cyc(); #1;
    n_vec++; if (instrStall !== 1'b0) begin n_err++; $display("FAIL fetch_stall_drop: got %b expected 0", instrStall); end
    n_vec++; if (inst_sram_rdata !== 32'h2408_0001) begin n_err++; $display("FAIL fetch_rdata: got %h expected 24080001", inst_sram_rdata); end
    cyc(); inst_sram_en = 1'b0;
    cyc();
  endtask

  task automatic test_concurrent();
    cyc(); inst_sram_en = 1'b1; inst_sram_addr = 32'h8000_0010;
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h8000_0010; #1;
    n_vec++; if ({instrStall, dataStall} !== 2'b11) begin n_err++; $display("FAIL conc_stalls0: got %b expected 11", {instrStall, dataStall}); end
    cyc(); mem_addr_ok = 1'b1; #1;
    n_vec++; if ({mem_req, mem_wstrb, mem_addr} !== {1'b1, 4'h0, 32'h0000_0010})
      begin n_err++; $display("FAIL conc_data_first: got req=%b wstrb=%h addr=%h expected 1/0/00000010", mem_req, mem_wstrb, mem_addr); end
    cyc(); mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_0010; #1;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL conc_wait_req: got %b expected 0", mem_req); end
    cyc(); #1;
    n_vec++; if ({instrStall, dataStall, mem_req} !== 3'b100) begin n_err++; $display("FAIL conc_mid: got istall/dstall/req=%b expected 100", {instrStall, dataStall, mem_req}); end
    n_vec++; if (data_sram_rdata !== 32'hAAAA_0010) begin n_err++; $display("FAIL conc_data_hold: got %h expected aaaa0010", data_sram_rdata); end
    cyc(); mem_addr_ok = 1'b1; #1;
    n_vec++; if ({mem_req, mem_wstrb, mem_addr} !== {1'b1, 4'h0, 32'h0000_0010})
      begin n_err++; $display("FAIL conc_fetch_req: got req=%b wstrb=%h addr=%h expected 1/0/00000010", mem_req, mem_wstrb, mem_addr); end
    cyc(); mem_data_ok = 1'b1; mem_rdata = 32'hBBBB_0010; #1;
    n_vec++; if (instrStall !== 1'b1) begin n_err++; $display("FAIL conc_fetch_wait: got %b expected 1", instrStall); end
    cyc(); #1;
    n_vec++; if ({instrStall, dataStall} !== 2'b00) begin n_err++; $display("FAIL conc_advance: got %b expected 00", {instrStall, dataStall}); end
    n_vec++; if ({inst_sram_rdata, data_sram_rdata} !== {32'hBBBB_0010, 32'hAAAA_0010})
      begin n_err++; $display("FAIL conc_results: got %h/%h expected bbbb0010/aaaa0010", inst_sram_rdata, data_sram_rdata); end
    cyc(); inst_sram_en = 1'b0; data_sram_en = 1'b0;
    cyc();
  endtask

  task automatic test_store_backpressure();
    cyc(); data_sram_en = 1'b1; data_sram_wen = 4'b0011;
    data_sram_wdata = 32'h1234_5678; data_sram_addr = 32'h0040_0000; #1;
    n_vec++; if (dataStall !== 1'b1) begin n_err++; $display("FAIL store_stall0: got %b expected 1", dataStall); end
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      n_vec++;
      if ({mem_req, mem_wstrb, mem_addr, mem_wdata} !== {1'b1, 4'b0011, 32'h0040_0000, 32'h1234_5678})
        begin n_err++; $display("FAIL store_hold[%0d]: got req=%b wstrb=%h addr=%h wdata=%h", i, mem_req, mem_wstrb, mem_addr, mem_wdata); end
    end
    cyc(); mem_addr_ok = 1'b1; #1;
    n_vec++; if ({mem_req, mem_wstrb, mem_addr, mem_wdata} !== {1'b1, 4'b0011, 32'h0040_0000, 32'h1234_5678})
      begin n_err++; $display("FAIL store_accept: got req=%b wstrb=%h addr=%h wdata=%h", mem_req, mem_wstrb, mem_addr, mem_wdata); end
    cyc(); mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    n_vec++; if ({mem_req, dataStall} !== 2'b01) begin n_err++; $display("FAIL store_wait: got req/stall=%b expected 01", {mem_req, dataStall}); end
    cyc(); #1;
    n_vec++; if (dataStall !== 1'b0) begin n_err++; $display("FAIL store_done: got %b expected 0", dataStall); end
    n_vec++; if (data_sram_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL store_rdata: got %h expected deadbeef", data_sram_rdata); end
    cyc(); data_sram_en = 1'b0; data_sram_wen = '0;
    cyc();
  endtask

  task automatic test_hold();
    int base;
    base = acc_cnt;
    cyc(); inst_sram_en = 1'b1; inst_sram_addr = 32'h0040_0100; #1;
    cyc(); data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h0000_2000; mem_addr_ok = 1'b1; #1;
    n_vec++; if ({mem_req, mem_addr} !== {1'b1, 32'h0040_0100}) begin n_err++; $display("FAIL hold_fetch_req: got req=%b addr=%h expected 1/00400100", mem_req, mem_addr); end
    cyc(); mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_0001; #1;
    cyc(); #1;
    n_vec++; if ({instrStall, dataStall} !== 2'b01) begin n_err++; $display("FAIL hold_partial: got %b expected 01", {instrStall, dataStall}); end
    n_vec++; if (inst_sram_rdata !== 32'hCAFE_0001) begin n_err++; $display("FAIL hold_inst_rdata: got %h expected cafe0001", inst_sram_rdata); end
    for (int i = 0; i < 6; i++) begin
      cyc(); #1;
      n_vec++;
      if ({mem_req, mem_addr, instrStall, inst_sram_rdata} !== {1'b1, 32'h0000_2000, 1'b0, 32'hCAFE_0001})
        begin n_err++; $display("FAIL hold_wait[%0d]: got req=%b addr=%h istall=%b irdata=%h", i, mem_req, mem_addr, instrStall, inst_sram_rdata); end
    end
    cyc(); mem_addr_ok = 1'b1; #1;
    cyc(); mem_data_ok = 1'b1; mem_rdata = 32'hBEEF_0002; #1;
    cyc(); #1;
    n_vec++; if ({instrStall, dataStall} !== 2'b00) begin n_err++; $display("FAIL hold_advance: got %b expected 00", {instrStall, dataStall}); end
    n_vec++; if ({inst_sram_rdata, data_sram_rdata} !== {32'hCAFE_0001, 32'hBEEF_0002})
      begin n_err++; $display("FAIL hold_results: got %h/%h expected cafe0001/beef0002", inst_sram_rdata, data_sram_rdata); end
    n_vec++; if (acc_cnt - base !== 2) begin n_err++; $display("FAIL hold_req_count: got %0d expected 2", acc_cnt - base); end
    cyc(); inst_sram_en = 1'b0; data_sram_en = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    cyc(); data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h8000_0040; #1;
    cyc(); mem_addr_ok = 1'b1; #1;
    n_vec++; if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0040}) begin n_err++; $display("FAIL rmid_req: got req=%b addr=%h expected 1/00000040", mem_req, mem_addr); end
    cyc(); #1;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rmid_wait: got %b expected 0", mem_req); end
    cyc(); rst = 1'b1; #1;
    cyc(); rst = 1'b0; #1;
    n_vec++; if ({mem_req, instrStall, dataStall} !== 3'b001) begin n_err++; $display("FAIL rmid_after: got req/istall/dstall=%b expected 001", {mem_req, instrStall, dataStall}); end
    n_vec++; if (data_sram_rdata !== 32'h0) begin n_err++; $display("FAIL rmid_rdata_clear: got %h expected 0", data_sram_rdata); end
    cyc(); mem_addr_ok = 1'b1; #1;
    n_vec++; if ({mem_req, mem_addr} !== {1'b1, 32'h0000_0040}) begin n_err++; $display("FAIL rmid_reissue: got req=%b addr=%h expected 1/00000040", mem_req, mem_addr); end
    cyc(); mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_F00D; #1;
    cyc(); #1;
    n_vec++; if ({dataStall, data_sram_rdata} !== {1'b0, 32'h0BAD_F00D}) begin n_err++; $display("FAIL rmid_complete: got stall=%b rdata=%h expected 0/0badf00d", dataStall, data_sram_rdata); end
    cyc(); data_sram_en = 1'b0;
    cyc();
  endtask

  task automatic test_inst_first();
    cyc(); a_inst_sram_en = 1'b1; a_inst_sram_addr = 32'hBFC0_0000;
    a_data_sram_en = 1'b1; a_data_sram_wen = 4'hF; a_data_sram_addr = 32'h8000_0020; a_data_sram_wdata = 32'h5555_AAAA; #1;
    n_vec++; if ({a_instrStall, a_dataStall, a_mem_req} !== 3'b110) begin n_err++; $display("FAIL alt_idle: got %b expected 110", {a_instrStall, a_dataStall, a_mem_req}); end
    cyc(); a_mem_addr_ok = 1'b1; #1;
    n_vec++; if ({a_mem_req, a_mem_wstrb, a_mem_addr, a_mem_wdata} !== {1'b1, 4'h0, 32'hBFC0_0000, 32'h0})
      begin n_err++; $display("FAIL alt_fetch_first: got req=%b wstrb=%h addr=%h wdata=%h", a_mem_req, a_mem_wstrb, a_mem_addr, a_mem_wdata); end
    cyc(); a_mem_data_ok = 1'b1; a_mem_rdata = 32'h1111_2222; #1;
    cyc(); #1;
    n_vec++; if ({a_instrStall, a_dataStall, a_inst_sram_rdata} !== {2'b01, 32'h1111_2222})
      begin n_err++; $display("FAIL alt_fetch_done: got stalls=%b rdata=%h expected 01/11112222", {a_instrStall, a_dataStall}, a_inst_sram_rdata); end
    cyc(); a_mem_addr_ok = 1'b1; #1;
    n_vec++; if ({a_mem_req, a_mem_wstrb, a_mem_addr, a_mem_wdata} !== {1'b1, 4'hF, 32'h8000_0020, 32'h5555_AAAA})
      begin n_err++; $display("FAIL alt_data_raw: got req=%b wstrb=%h addr=%h wdata=%h", a_mem_req, a_mem_wstrb, a_mem_addr, a_mem_wdata); end
    cyc(); a_mem_data_ok = 1'b1; a_mem_rdata = 32'h3333_4444; #1;
    cyc(); #1;
    n_vec++; if ({a_instrStall, a_dataStall, a_data_sram_rdata} !== {2'b00, 32'h3333_4444})
      begin n_err++; $display("FAIL alt_data_done: got stalls=%b rdata=%h expected 00/33334444", {a_instrStall, a_dataStall}, a_data_sram_rdata); end
    cyc(); a_inst_sram_en = 1'b0; a_data_sram_en = 1'b0;
    cyc();
  endtask

  task automatic test_random(input int unsigned n_steps);
    txn_t        exp_q[$];
    txn_t        t, cur;
    logic [31:0] exp_i, exp_d, ma;
    logic        busy, i_dn, d_dn, fire_i, fire_d, fin;
    int unsigned cnt, cycles;
    exp_i = '0; exp_d = '0;
    cur = '{default: '0};
    for (int unsigned s = 0; s < n_steps; s++) begin
      cyc();
      inst_sram_en    = ($urandom_range(0, 3) != 0);
      data_sram_en    = 1'($urandom_range(0, 1));
      inst_sram_addr  = rand_addr();
      data_sram_addr  = rand_addr();
      data_sram_wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      data_sram_wdata = $urandom;
      exp_q.delete();
      if (data_sram_en) begin
        ma = map_addr(data_sram_addr);
        t.is_inst = 1'b0; t.addr = ma; t.wstrb = data_sram_wen; t.wdata = data_sram_wdata;
        t.rdata = (data_sram_wen == 4'h0) ? mem_read(ma) : ~ma;
        if (data_sram_wen != 4'h0) mem_write(ma, data_sram_wen, data_sram_wdata);
        exp_d = t.rdata;
        exp_q.push_back(t);
      end
      if (inst_sram_en) begin
        ma = map_addr(inst_sram_addr);
        t.is_inst = 1'b1; t.addr = ma; t.wstrb = 4'h0; t.wdata = 32'h0;
        t.rdata = mem_read(ma);
        exp_i = t.rdata;
        exp_q.push_back(t);
      end
      i_dn = 1'b0; d_dn = 1'b0; busy = 1'b0; cnt = 0; fin = 1'b0; cycles = 0;
      while (!fin) begin
        if (cycles != 0) cyc();
        mem_rdata = $urandom;
        fire_i = 1'b0; fire_d = 1'b0;
        if (busy) begin
          if (cnt == 0) begin
            mem_data_ok = 1'b1; mem_rdata = cur.rdata; busy = 1'b0;
            fire_i = cur.is_inst; fire_d = ~cur.is_inst;
          end else begin
            cnt--;
          end
        end
        #1;
        n_vec++; if (instrStall !== (inst_sram_en & ~i_dn))
          begin n_err++; $display("FAIL rnd_instrStall step %0d: got %b expected %b", s, instrStall, inst_sram_en & ~i_dn); end
        n_vec++; if (dataStall !== (data_sram_en & ~d_dn))
          begin n_err++; $display("FAIL rnd_dataStall step %0d: got %b expected %b", s, dataStall, data_sram_en & ~d_dn); end
        n_vec++; if ((busy || mem_data_ok) && mem_req !== 1'b0)
          begin n_err++; $display("FAIL rnd_outstanding step %0d: got req=%b expected 0", s, mem_req); end
        if (!busy && !mem_data_ok && mem_req === 1'b1 && $urandom_range(0, 1) == 1) begin
          mem_addr_ok = 1'b1;
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++; $display("FAIL rnd_extra_req step %0d: got addr=%h expected no request", s, mem_addr);
          end else begin
            t = exp_q.pop_front();
            if ({mem_wstrb, mem_addr, mem_wdata} !== {t.wstrb, t.addr, t.wdata}) begin
              n_err++;
              $display("FAIL rnd_txn step %0d: got wstrb=%h addr=%h wdata=%h expected %h/%h/%h",
                       s, mem_wstrb, mem_addr, mem_wdata, t.wstrb, t.addr, t.wdata);
            end
            cur = t; busy = 1'b1; cnt = $urandom_range(0, 2);
          end
        end
        if (!(inst_sram_en & ~i_dn) && !(data_sram_en & ~d_dn)) begin
          if (inst_sram_en) begin
            n_vec++; if (inst_sram_rdata !== exp_i)
              begin n_err++; $display("FAIL rnd_inst_rdata step %0d: got %h expected %h", s, inst_sram_rdata, exp_i); end
          end
          if (data_sram_en) begin
            n_vec++; if (data_sram_rdata !== exp_d)
              begin n_err++; $display("FAIL rnd_data_rdata step %0d: got %h expected %h", s, data_sram_rdata, exp_d); end
          end
          fin = 1'b1;
        end
        if (fire_i) i_dn = 1'b1;
        if (fire_d) d_dn = 1'b1;
        cycles++;
        if (!fin && cycles > 60) begin
          n_vec++; n_err++;
          $display("FAIL rnd_timeout step %0d: got no advance within 60 cycles expected completion", s);
          cyc(); rst = 1'b1; inst_sram_en = 1'b0; data_sram_en = 1'b0;
          cyc(); rst = 1'b0;
          fin = 1'b1;
        end
      end
    end
    cyc(); inst_sram_en = 1'b0; data_sram_en = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_concurrent();
    test_store_backpressure();
    test_hold();
    test_reset_mid();
    test_inst_first();
    test_random(300);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
